// File: rtl/alu_arbiter_if.sv
// Request/response bundle for the shared ALU: two valid/ready request
// channels in, one valid/ready response channel out.
interface alu_arbiter_if #(
    parameter int DATA_W = 4,
    parameter int OP_W   = 3
);
    logic              req0_valid;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic [OP_W-1:0]   req0_op;
    logic              req0_ready;

    logic              req1_valid;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic [OP_W-1:0]   req1_op;
    logic              req1_ready;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero;
    logic              rsp_carry;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_carry
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_carry
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin share of one registered ALU stage between two requesters,
// with a single backpressured response channel and per-requester counters.
module alu_arbiter #(
    parameter int DATA_W = 4,
    parameter int OP_W   = 3,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    alu_arbiter_if.slave     bus,
    output logic             busy,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   op;
        logic              id;
    } op_t;

    state_t                 state_q, state_d;
    logic                   rr_q, rr_d;
    op_t                    op_q, op_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]      rsp_result_q, rsp_result_d;
    logic                   rsp_zero_q, rsp_zero_d;
    logic                   rsp_carry_q, rsp_carry_d;
    logic [1:0][CNT_W-1:0]  cnt_q, cnt_d;

    logic [1:0]             vld, rdy;
    logic                   gnt;
    logic [1:0][DATA_W-1:0] a_in, b_in;
    logic [1:0][OP_W-1:0]   op_in;
    logic [DATA_W:0]        alu_wide;

    assign vld   = {bus.req1_valid, bus.req0_valid};
    assign a_in  = {bus.req1_a, bus.req0_a};
    assign b_in  = {bus.req1_b, bus.req0_b};
    assign op_in = {bus.req1_op, bus.req0_op};

    // The pointer only breaks ties; a lone valid always wins.
    assign gnt    = (vld == 2'b11) ? rr_q : vld[1];
    assign rdy[0] = (state_q == IDLE) && vld[0] && !gnt;
    assign rdy[1] = (state_q == IDLE) && vld[1] && gnt;

    // Bit DATA_W of the widened sum/difference is the carry or the borrow.
    always_comb begin
        alu_wide = '0;
        case (op_q.op)
            OP_W'(0): alu_wide = {1'b0, op_q.a} + {1'b0, op_q.b};
            OP_W'(1): alu_wide = {1'b0, op_q.a} - {1'b0, op_q.b};
            OP_W'(2): alu_wide = {1'b0, op_q.a & op_q.b};
            OP_W'(3): alu_wide = {1'b0, op_q.a | op_q.b};
            OP_W'(4): alu_wide = {1'b0, op_q.a ^ op_q.b};
            default:  alu_wide = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        op_d         = op_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_carry_d  = rsp_carry_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                if (|(vld & rdy)) begin
                    op_d    = '{a: a_in[gnt], b: b_in[gnt], op: op_in[gnt], id: gnt};
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_result_d = alu_wide[DATA_W-1:0];
                rsp_zero_d   = (alu_wide[DATA_W-1:0] == '0);
                rsp_carry_d  = alu_wide[DATA_W];
                rsp_id_d     = op_q.id;
                rsp_valid_d  = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (cnt_q[rsp_id_q] != '1)
                        cnt_d[rsp_id_q] = cnt_q[rsp_id_q] + 1'b1;
                    rr_d    = ~rsp_id_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_q         <= 1'b0;
            op_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_carry_q  <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            op_q         <= op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_carry_q  <= rsp_carry_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.req0_ready = rdy[0];
    assign bus.req1_ready = rdy[1];
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign bus.rsp_carry  = rsp_carry_q;
    assign busy           = (state_q != IDLE);
    assign cnt0           = cnt_q[0];
    assign cnt1           = cnt_q[1];
endmodule

// File: tb/tb_alu_arbiter.sv
// Random and directed traffic on both requesters; a negedge monitor scores
// grants, responses, latency, stability and counters against a plain model.
module tb_alu_arbiter;
    localparam int DATA_W  = 4;
    localparam int OP_W    = 3;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        logic [3:0] res;
        logic       zero;
        logic       carry;
        int         t;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             busy;
    logic [CNT_W-1:0] cnt0, cnt1;

    alu_arbiter_if #(.DATA_W(DATA_W), .OP_W(OP_W)) bus();

    alu_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .busy (busy),
        .cnt0 (cnt0),
        .cnt1 (cnt1)
    );

    always #5 clk = ~clk;

    // driver state
    bit         dv [2];
    bit  [3:0]  da [2];
    bit  [3:0]  db [2];
    bit  [2:0]  dop[2];
    int         issued[2];
    bit         rsp_rdy;
    // main-controlled knobs
    int         target[2];
    bit         gaps;
    int         rr_mode;
    bit         done;
    int         timeouts;
    bit  [10:0] tab   [2][64];
    bit         tab_en[2][64];
    // monitor state
    bit         hs[2];
    int         cyc;
    int         tests, fails;
    int         cm0, cm1;
    bit         pref, in_rsp, hs_last, rst_seen;
    logic [6:0] snap;
    exp_t       q0[$];
    exp_t       q1[$];

    assign bus.req0_valid = dv[0];
    assign bus.req0_a     = da[0];
    assign bus.req0_b     = db[0];
    assign bus.req0_op    = dop[0];
    assign bus.req1_valid = dv[1];
    assign bus.req1_a     = da[1];
    assign bus.req1_b     = db[1];
    assign bus.req1_op    = dop[1];
    assign bus.rsp_ready  = rsp_rdy;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(int a, int b, int op, int t);
        exp_t e;
        int   r;
        e.carry = 1'b0;
        case (op)
            0: begin r = a + b; e.carry = (r > 15); r = r % 16; end
            1: begin e.carry = (a < b); r = (a - b + 16) % 16; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            default: r = 0;
        endcase
        e.res  = 4'(r);
        e.zero = (r == 0);
        e.t    = t;
        return e;
    endfunction

    task automatic chk(string name, int act, int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Requesters: present an op while issued < target; re-present at once after a handshake.
    always @(posedge clk) begin
        #1;
        for (int n = 0; n < 2; n++) begin
            if (hs[n]) begin
                issued[n]++;
                dv[n] = 1'b0;
            end
            if (issued[n] < target[n]) begin
                if (!dv[n] && (!gaps || $urandom_range(0, 2) == 0)) begin
                    dv[n] = 1'b1;
                    if (issued[n] < 64 && tab_en[n][issued[n]]) begin
                        {da[n], db[n], dop[n]} = tab[n][issued[n]];
                    end else begin
                        da[n]  = 4'($urandom_range(0, 15));
                        db[n]  = 4'($urandom_range(0, 15));
                        dop[n] = 3'($urandom_range(0, 7));
                    end
                end else if (dv[n] && gaps && $urandom_range(0, 3) == 0 &&
                             !(issued[n] < 64 && tab_en[n][issued[n]])) begin
                    da[n]  = 4'($urandom_range(0, 15));
                    db[n]  = 4'($urandom_range(0, 15));
                    dop[n] = 3'($urandom_range(0, 7));
                end
            end else begin
                dv[n] = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        case (rr_mode)
            0:       rsp_rdy = 1'b1;
            1:       rsp_rdy = 1'($urandom_range(0, 1));
            default: rsp_rdy = 1'b0;
        endcase
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [1:0] rdy, vld, exp_rdy;
        bit         busy_exp;
        exp_t       e;
        logic [6:0] cur;
        rdy = {bus.req1_ready, bus.req0_ready};
        vld = {dv[1], dv[0]};
        cur = {bus.rsp_id, bus.rsp_result, bus.rsp_zero, bus.rsp_carry};
        if (rst) begin
            q0.delete();
            q1.delete();
            cm0 = 0; cm1 = 0;
            pref = 1'b0; in_rsp = 1'b0; hs_last = 1'b0;
            hs[0] = 1'b0; hs[1] = 1'b0;
            rst_seen = 1'b1;
        end else begin
            if (rst_seen) begin
                chk("reset_rsp", int'({bus.rsp_valid, cur}), 0);
                rst_seen = 1'b0;
            end
            chk("cnt0", int'(cnt0), cm0);
            chk("cnt1", int'(cnt1), cm1);
            busy_exp = hs_last || bus.rsp_valid;
            chk("busy", int'(busy), int'(busy_exp));
            if (!busy_exp)
                exp_rdy = (vld == 2'b11) ? (pref ? 2'b10 : 2'b01) : vld;
            else
                exp_rdy = 2'b00;
            chk("ready", int'(rdy), int'(exp_rdy));

            if (bus.rsp_valid) begin
                if (!in_rsp) begin
                    if (bus.rsp_id ? (q1.size() == 0) : (q0.size() == 0)) begin
                        chk("rsp_unexpected_id", int'(bus.rsp_id), -1);
                    end else begin
                        e = bus.rsp_id ? q1.pop_front() : q0.pop_front();
                        chk("rsp_result", int'(bus.rsp_result), int'(e.res));
                        chk("rsp_zero", int'(bus.rsp_zero), int'(e.zero));
                        chk("rsp_carry", int'(bus.rsp_carry), int'(e.carry));
                        chk("rsp_latency", cyc - e.t, 2);
                    end
                end else begin
                    chk("rsp_stable", int'(cur), int'(snap));
                end
                snap   = cur;
                in_rsp = !bus.rsp_ready;
                if (bus.rsp_ready) begin
                    if (bus.rsp_id) cm1 = (cm1 < CNT_MAX) ? cm1 + 1 : cm1;
                    else            cm0 = (cm0 < CNT_MAX) ? cm0 + 1 : cm0;
                    pref = !bus.rsp_id;
                end
            end

            hs_last = 1'b0;
            for (int n = 0; n < 2; n++) begin
                hs[n] = vld[n] && rdy[n];
                if (hs[n]) begin
                    e = model(int'(da[n]), int'(db[n]), int'(dop[n]), cyc);
                    if (n == 0) q0.push_back(e);
                    else        q1.push_back(e);
                    hs_last = 1'b1;
                end
            end

            if (done) begin
                chk("issued0", issued[0], target[0]);
                chk("issued1", issued[1], target[1]);
                chk("pending0", q0.size(), 0);
                chk("pending1", q1.size(), 0);
                chk("timeouts", timeouts, 0);
                $display("[TB] %0d tests run, %0d failed", tests, fails);
                $finish;
            end
        end
    end

    task automatic wait_idle(int limit);
        int k = 0;
        do begin
            @(posedge clk); #2;
            k++;
        end while (k < limit && !(issued[0] == target[0] && issued[1] == target[1] &&
                                  !busy && !bus.rsp_valid));
        if (k >= limit) timeouts++;
        @(posedge clk); #2;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    initial begin
        int k;
        tab[0][0] = {4'h7, 4'h9, 3'b000}; tab_en[0][0] = 1'b1;
        tab[1][0] = {4'h3, 4'h5, 3'b001}; tab_en[1][0] = 1'b1;
        tab[1][1] = {4'hF, 4'hA, 3'b010}; tab_en[1][1] = 1'b1;
        tab[1][2] = {4'h5, 4'h6, 3'b110}; tab_en[1][2] = 1'b1;
        rr_mode = 0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // single-requester directed ops
        target[0] = 1;
        wait_idle(50);
        target[1] = 3;
        wait_idle(50);

        // both held valid: strict alternation from requester 0
        do_reset();
        target[0] += 3;
        target[1] += 3;
        wait_idle(100);

        // backpressure for 5 cycles in RESP
        rr_mode = 2;
        target[0] += 1;
        k = 0;
        while (!bus.rsp_valid && k < 20) begin @(posedge clk); #2; k++; end
        if (k >= 20) timeouts++;
        repeat (5) @(posedge clk);
        #2 rr_mode = 0;
        wait_idle(50);

        // reset while EXEC holds an op; pointer must come back to requester 0
        target[0] += 1;
        k = 0;
        while (!(busy && !bus.rsp_valid) && k < 20) begin @(posedge clk); #2; k++; end
        if (k >= 20) timeouts++;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        target[0] += 1;
        target[1] += 1;
        wait_idle(50);

        // saturation: 5 ops on requester 0
        do_reset();
        target[0] += 5;
        wait_idle(100);

        // random traffic with gaps, operand churn and random backpressure
        gaps    = 1'b1;
        rr_mode = 1;
        target[0] += 150;
        target[1] += 150;
        wait_idle(6000);

        done = 1'b1;
        repeat (5) @(posedge clk);
        $display("FAIL monitor_finish: got 0 expected 1");
        $fatal(1, "monitor did not finish");
    end
endmodule
